tsc_buf_rx: RTL and testbench

TSC_BUF_RX -- requirements
Module: tsc_buf_rx

---
 rtl/tsc_buf_rx.sv | 131 +++++++++++++
 tb/tb_tsc_buf_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tsc_buf_rx.sv
// Receive-side buffer for a trigger/serial capture unit: arms on request, asks the
// capture unit for its buffer on the next trigger rise, stores the streamed bytes.
//
// state | meaning
// IDLE  | waiting for arm; results of the last transfer held
// ARMED | waiting for a rising edge on trd
// REQ   | one-cycle sbf request to the capture unit
// RECV  | storing strobed bytes until cd or idle timeout
// FIN   | one-cycle done pulse
module tsc_buf_rx #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          trd,
  output logic          sbf,
  input  logic [8:0]    sd,
  input  logic          cd,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   byte_cnt,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          tmo
);

  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_REQ   = 3'd2,
    S_RECV  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          trd_q;
  logic [TW-1:0] tcnt;
  logic [7:0]    mem [DEPTH];

  logic strobe;
  logic trd_rise;
  logic full;
  logic wr_en;
  logic tc_hit;

  assign strobe   = sd[8];
  assign trd_rise = trd & ~trd_q;
  assign full     = (byte_cnt == FULL);
  assign wr_en    = (state == S_RECV) && strobe && !full;
  // Idle-cycle down-counter reaches terminal count with nothing arriving this cycle
  assign tc_hit   = (state == S_RECV) && !strobe && !cd && (tcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm)      state_nxt = S_ARMED;
      S_ARMED: if (trd_rise) state_nxt = S_REQ;
      S_REQ:                 state_nxt = S_RECV;
      S_RECV:  if (cd || tc_hit) state_nxt = S_FIN;
      S_FIN:                 state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sbf  = (state == S_REQ);
    done = (state == S_FIN);
    busy = (state == S_ARMED) || (state == S_REQ) || (state == S_RECV);
  end

  // trd history runs in every state so a level already high at arm needs a fresh rise
  always_ff @(posedge clk) begin
    if (rst) trd_q <= 1'b0;
    else     trd_q <= trd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      ovf      <= 1'b0;
      tmo      <= 1'b0;
      tcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm) begin
            byte_cnt <= '0;
            ovf      <= 1'b0;
            tmo      <= 1'b0;
          end
        end
        S_REQ: tcnt <= TLOAD;
        S_RECV: begin
          if (strobe) begin
            if (!full) byte_cnt <= byte_cnt + 1'b1;
            else       ovf      <= 1'b1;
          end
          if (strobe || cd)    tcnt <= TLOAD;
          else if (tcnt != '0) tcnt <= tcnt - 1'b1;
          else                 tmo  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Buffer is deliberately left out of reset so a capture survives a controller reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[byte_cnt[AW-1:0]] <= sd[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_tsc_buf_rx.sv
// Self-checking bench for tsc_buf_rx: directed scenarios plus randomized transfers
// checked against a byte-queue model of the buffer.
module tb_tsc_buf_rx;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          trd;
  logic          sbf;
  logic [8:0]    sd;
  logic          cd;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW:0]   byte_cnt;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          tmo;

  always #5 clk = ~clk;

  tsc_buf_rx #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trd(trd), .sbf(sbf), .sd(sd), .cd(cd),
    .rd_addr(rd_addr), .rd_data(rd_data), .byte_cnt(byte_cnt), .busy(busy),
    .done(done), .ovf(ovf), .tmo(tmo)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int sbf_seen  = 0;
  int done_seen = 0;

  logic [7:0] m_mem [DEPTH];
  bit         m_vld [DEPTH];
  int         m_cnt = 0;
  bit         m_ovf = 0;

  always @(negedge clk) begin
    if (sbf === 1'b1)  sbf_seen++;
    if (done === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (m_cnt < DEPTH) begin
      m_mem[m_cnt] = b;
      m_vld[m_cnt] = 1'b1;
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_cd);
    sd = {1'b1, b};
    cd = with_cd;
    tick();
    sd = '0;
    cd = 1'b0;
    m_byte(b);
  endtask

  // Idle cycles inside RECV; stray arm pulses there must be ignored
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      arm = ($urandom_range(0, 3) == 0);
      tick();
    end
    arm = 1'b0;
  endtask

  task automatic readback();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      tick();
      if (m_vld[a]) chk($sformatf("rd[%0d]", a), {24'h0, rd_data}, {24'h0, m_mem[a]});
    end
  endtask

  // Arms, fires a clean trd rise, and returns sampled in the first RECV cycle
  task automatic arm_and_trigger();
    int s0;
    trd = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    arm   = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    chk("armed_busy", {31'h0, busy}, 1);
    chk("arm_clr_cnt", {26'h0, byte_cnt}, 0);
    chk("arm_clr_ovf", {31'h0, ovf}, 0);
    chk("arm_clr_tmo", {31'h0, tmo}, 0);
    repeat ($urandom_range(0, 3)) begin
      sd = {1'b1, 8'($urandom)};
      cd = 1'($urandom);
      tick();
    end
    sd = '0;
    cd = 1'b0;
    s0 = sbf_seen;
    trd = 1'b1;
    tick();
    chk("sbf_latency", {31'h0, sbf}, 1);
    sd  = {1'b1, 8'hEE};
    trd = 1'($urandom);
    tick();
    sd = '0;
    chk("sbf_one_cycle", {31'h0, sbf}, 0);
    chk("sbf_count", sbf_seen - s0, 1);
  endtask

  task automatic run_xfer(input int nb, input bit coinc, input bit rnd, input int base);
    int d0;
    logic [7:0] b;
    d0 = done_seen;
    arm_and_trigger();
    for (int i = 0; i < nb; i++) begin
      gap($urandom_range(0, 4));
      b = rnd ? 8'($urandom) : 8'(base + i);
      send_byte(b, coinc && (i == nb - 1));
    end
    if (!coinc) begin
      gap($urandom_range(0, 4));
      cd = 1'b1;
      tick();
      cd = 1'b0;
    end
    chk("done_pulse", {31'h0, done}, 1);
    chk("byte_cnt", {26'h0, byte_cnt}, m_cnt);
    chk("ovf", {31'h0, ovf}, {31'h0, m_ovf});
    chk("tmo_clear", {31'h0, tmo}, 0);
    tick();
    chk("done_low", {31'h0, done}, 0);
    chk("idle_busy", {31'h0, busy}, 0);
    chk("done_count", done_seen - d0, 1);
    readback();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    int n;
    rst = 1'b1; arm = 1'b0; trd = 1'b0; sd = '0; cd = 1'b0; rd_addr = '0;
    repeat (3) tick();
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_sbf", {31'h0, sbf}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_ovf", {31'h0, ovf}, 0);
    chk("rst_tmo", {31'h0, tmo}, 0);
    chk("rst_cnt", {26'h0, byte_cnt}, 0);
    chk("rst_rd_data", {24'h0, rd_data}, 0);
    rst = 1'b0;
    tick();

    run_xfer(8, 1'b0, 1'b0, 1);
    run_xfer(40, 1'b0, 1'b0, 0);
    chk("ovf_sticky_cnt", {26'h0, byte_cnt}, 32);
    run_xfer(5, 1'b1, 1'b0, 'hA1);

    // Idle timeout: done exactly TIMEOUT cycles after RECV entry
    arm_and_trigger();
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, TIMEOUT);
    chk("tmo_flag", {31'h0, tmo}, 1);
    chk("tmo_cnt", {26'h0, byte_cnt}, 0);
    tick();
    chk("tmo_idle", {31'h0, busy}, 0);

    // trd already high when armed: needs a fall then a rise
    trd = 1'b1;
    repeat (2) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    s0 = sbf_seen;
    repeat (5) tick();
    chk("trd_high_no_sbf", sbf_seen - s0, 0);
    chk("trd_high_busy", {31'h0, busy}, 1);
    trd = 1'b0;
    tick();
    chk("trd_fall_no_sbf", {31'h0, sbf}, 0);
    trd = 1'b1;
    tick();
    chk("trd_rise_sbf", {31'h0, sbf}, 1);
    tick();
    chk("trd_sbf_once", sbf_seen - s0, 1);
    cd = 1'b1;
    tick();
    cd = 1'b0;
    chk("trd_done", {31'h0, done}, 1);
    tick();

    // Reset mid-transfer after 3 of 8 bytes
    d0 = done_seen;
    arm_and_trigger();
    for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = 0;
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_cnt", {26'h0, byte_cnt}, 0);
    chk("mid_rst_rd_data", {24'h0, rd_data}, 0);
    for (int i = 3; i < 8; i++) begin
      sd = {1'b1, 8'h50 + 8'(i)};
      tick();
    end
    sd = '0;
    cd = 1'b1;
    tick();
    cd = 1'b0;
    tick();
    chk("mid_rst_no_done", done_seen - d0, 0);
    chk("mid_rst_cnt_after", {26'h0, byte_cnt}, 0);
    chk("mid_rst_idle", {31'h0, busy}, 0);
    readback();
    run_xfer(8, 1'b0, 1'b0, 1);

    repeat (6) begin
      n = $urandom_range(0, 45);
      run_xfer(n, (n > 0) && ($urandom_range(0, 1) == 1), 1'b1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
